// File: rtl/div_unit_multi.sv
// Multi-cycle integer divider for the execution stage.
// Retires BITS_PER_CYCLE quotient bits per iteration using chained restoring
// steps, and returns either the quotient or the remainder. One operation is in
// flight at a time, with valid/ready handshakes toward the reservation station
// and the CDB arbiter.
module div_unit_multi #(
  parameter int RS_ID_WIDTH    = 5,
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic [WIDTH-1:0]       op1,
  input  logic [WIDTH-1:0]       op2,
  input  logic                   div_signed,
  input  logic                   want_remainder,
  input  logic                   alter_OV,
  input  logic                   alter_CR0,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [WIDTH-1:0]       result,
  output logic                   ov,
  output logic                   ov_valid,
  output logic                   cr0_valid
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0]    LAST    = CW'(ITERS - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]       dvd_r;
  logic [WIDTH-1:0]       dvs_r;
  logic [WIDTH-1:0]       quo_r;
  logic [WIDTH:0]         acc_r;
  logic [WIDTH-1:0]       res_r;
  logic [CW-1:0]          cnt_r;
  logic                   sgn_r;
  logic                   rem_r;
  logic                   qneg_r;
  logic                   rneg_r;
  logic                   ov_r;
  logic                   aov_r;
  logic                   acr_r;
  logic [RS_ID_WIDTH-1:0] rs_id_r;
  logic [4:0]             addr_r;

  logic                   accept;
  logic                   dvd_neg;
  logic                   dvs_neg;
  logic [WIDTH-1:0]       dvd_mag;
  logic [WIDTH-1:0]       dvs_mag;
  logic                   exc;
  logic [WIDTH:0]         acc_step;
  logic [WIDTH-1:0]       quo_step;
  logic [WIDTH-1:0]       quo_sel;
  logic [WIDTH-1:0]       rem_sel;

  assign input_ready = (state == IDLE) | ((state == DONE) & output_ready);
  assign accept      = input_valid & input_ready;

  // Operand signs and magnitudes, used during PREP; dvs_r still holds the raw
  // divisor in that cycle and is overwritten with its magnitude at PREP exit.
  assign dvd_neg = sgn_r & dvd_r[WIDTH-1];
  assign dvs_neg = sgn_r & dvs_r[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dvd_r + 1'b1) : dvd_r;
  assign dvs_mag = dvs_neg ? (~dvs_r + 1'b1) : dvs_r;
  assign exc     = (dvs_r == '0) | (sgn_r & (dvd_r == MIN_VAL) & (dvs_r == '1));

  // One iteration cycle: BITS_PER_CYCLE chained shift/compare/subtract steps.
  always_comb begin
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    a = acc_r;
    q = quo_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      a = {a[WIDTH-1:0], q[WIDTH-1]};
      q = {q[WIDTH-2:0], 1'b0};
      if (a >= {1'b0, dvs_r}) begin
        a    = a - {1'b0, dvs_r};
        q[0] = 1'b1;
      end
    end
    acc_step = a;
    quo_step = q;
  end

  // Apply the recorded signs to the values produced by the final iteration.
  assign quo_sel = qneg_r ? (~quo_step + 1'b1) : quo_step;
  assign rem_sel = rneg_r ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection; DONE can hand straight over to PREP on a new accept.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (input_valid) state_next = PREP;
      PREP: state_next = exc ? DONE : ITER;
      ITER: if (cnt_r == LAST) state_next = DONE;
      DONE: if (output_ready) state_next = input_valid ? PREP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, sign preparation, iteration and result latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r   <= '0;
      dvs_r   <= '0;
      quo_r   <= '0;
      acc_r   <= '0;
      res_r   <= '0;
      cnt_r   <= '0;
      sgn_r   <= 1'b0;
      rem_r   <= 1'b0;
      qneg_r  <= 1'b0;
      rneg_r  <= 1'b0;
      ov_r    <= 1'b0;
      aov_r   <= 1'b0;
      acr_r   <= 1'b0;
      rs_id_r <= '0;
      addr_r  <= '0;
    end else begin
      if (accept) begin
        dvd_r   <= op1;
        dvs_r   <= op2;
        sgn_r   <= div_signed;
        rem_r   <= want_remainder;
        aov_r   <= alter_OV;
        acr_r   <= alter_CR0;
        rs_id_r <= rs_id_in;
        addr_r  <= result_reg_addr_in;
      end
      case (state)
        PREP: begin
          qneg_r <= dvd_neg ^ dvs_neg;
          rneg_r <= dvd_neg;
          if (exc) begin
            res_r <= '0;
            ov_r  <= 1'b1;
          end else begin
            ov_r  <= 1'b0;
            acc_r <= '0;
            quo_r <= dvd_mag;
            dvs_r <= dvs_mag;
            cnt_r <= '0;
          end
        end
        ITER: begin
          acc_r <= acc_step;
          quo_r <= quo_step;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST) res_r <= rem_r ? rem_sel : quo_sel;
        end
        default: ;
      endcase
    end
  end

  assign output_valid        = (state == DONE);
  assign rs_id_out           = rs_id_r;
  assign result_reg_addr_out = addr_r;
  assign result              = res_r;
  assign ov                  = ov_r;
  assign ov_valid            = aov_r;
  assign cr0_valid           = acr_r;

endmodule

// File: tb/tb_div_unit_multi.sv
// Directed testbench for div_unit_multi: a 32-bit radix-2 instance and a
// 64-bit four-bits-per-cycle instance share clock and reset.
module tb_div_unit_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total  = 0;
  int passed = 0;

  // 32-bit, 1 bit per cycle instance signals
  logic        a_input_valid = 1'b0;
  logic        a_input_ready;
  logic [4:0]  a_rs_id_in = '0;
  logic [4:0]  a_addr_in = '0;
  logic [31:0] a_op1 = '0;
  logic [31:0] a_op2 = '0;
  logic        a_signed = 1'b0;
  logic        a_rem = 1'b0;
  logic        a_aov = 1'b0;
  logic        a_acr = 1'b0;
  logic        a_output_valid;
  logic        a_output_ready = 1'b0;
  logic [4:0]  a_rs_id_out;
  logic [4:0]  a_addr_out;
  logic [31:0] a_result;
  logic        a_ov;
  logic        a_ov_valid;
  logic        a_cr0_valid;

  // 64-bit, 4 bits per cycle instance signals
  logic        b_input_valid = 1'b0;
  logic        b_input_ready;
  logic [4:0]  b_rs_id_in = '0;
  logic [4:0]  b_addr_in = '0;
  logic [63:0] b_op1 = '0;
  logic [63:0] b_op2 = '0;
  logic        b_signed = 1'b0;
  logic        b_rem = 1'b0;
  logic        b_aov = 1'b0;
  logic        b_acr = 1'b0;
  logic        b_output_valid;
  logic        b_output_ready = 1'b0;
  logic [4:0]  b_rs_id_out;
  logic [4:0]  b_addr_out;
  logic [63:0] b_result;
  logic        b_ov;
  logic        b_ov_valid;
  logic        b_cr0_valid;

  div_unit_multi #(.RS_ID_WIDTH(5), .WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk(clk), .rst(rst),
    .input_valid(a_input_valid), .input_ready(a_input_ready),
    .rs_id_in(a_rs_id_in), .result_reg_addr_in(a_addr_in),
    .op1(a_op1), .op2(a_op2),
    .div_signed(a_signed), .want_remainder(a_rem),
    .alter_OV(a_aov), .alter_CR0(a_acr),
    .output_valid(a_output_valid), .output_ready(a_output_ready),
    .rs_id_out(a_rs_id_out), .result_reg_addr_out(a_addr_out),
    .result(a_result), .ov(a_ov), .ov_valid(a_ov_valid), .cr0_valid(a_cr0_valid)
  );

  div_unit_multi #(.RS_ID_WIDTH(5), .WIDTH(64), .BITS_PER_CYCLE(4)) dut64 (
    .clk(clk), .rst(rst),
    .input_valid(b_input_valid), .input_ready(b_input_ready),
    .rs_id_in(b_rs_id_in), .result_reg_addr_in(b_addr_in),
    .op1(b_op1), .op2(b_op2),
    .div_signed(b_signed), .want_remainder(b_rem),
    .alter_OV(b_aov), .alter_CR0(b_acr),
    .output_valid(b_output_valid), .output_ready(b_output_ready),
    .rs_id_out(b_rs_id_out), .result_reg_addr_out(b_addr_out),
    .result(b_result), .ov(b_ov), .ov_valid(b_ov_valid), .cr0_valid(b_cr0_valid)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Offer one op to the 32-bit unit and wait for its result; lat counts the
  // accept cycle as 1, and -1 means the result never appeared.
  task automatic issue32(input logic [31:0] x, input logic [31:0] y,
                         input logic sgn, input logic rem, input logic aov, input logic acr,
                         input logic [4:0] tag, input logic [4:0] addr, input logic ordy,
                         output int lat);
    bit found;
    @(negedge clk);
    a_op1 = x; a_op2 = y; a_signed = sgn; a_rem = rem; a_aov = aov; a_acr = acr;
    a_rs_id_in = tag; a_addr_in = addr; a_output_ready = ordy; a_input_valid = 1'b1;
    @(posedge clk);
    #1 a_input_valid = 1'b0;
    lat = 1;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (a_output_valid) begin found = 1'b1; break; end
      lat++;
    end
    if (!found) lat = -1;
  endtask

  // Same for the 64-bit unit.
  task automatic issue64(input logic [63:0] x, input logic [63:0] y,
                         input logic sgn, input logic rem, output int lat);
    bit found;
    @(negedge clk);
    b_op1 = x; b_op2 = y; b_signed = sgn; b_rem = rem; b_output_ready = 1'b1;
    b_input_valid = 1'b1;
    @(posedge clk);
    #1 b_input_valid = 1'b0;
    lat = 1;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (b_output_valid) begin found = 1'b1; break; end
      lat++;
    end
    if (!found) lat = -1;
  endtask

  // Reset values on both instances while rst is held.
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (a_output_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", a_output_valid); else passed++;
    total++; if (a_input_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", a_input_ready); else passed++;
    total++; if (a_result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 0", a_result); else passed++;
    total++; if ({a_ov, a_ov_valid, a_cr0_valid} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {a_ov, a_ov_valid, a_cr0_valid}); else passed++;
    total++; if (a_rs_id_out !== 5'd0) $display("[TB] FAIL reset_tag: got %0d expected 0", a_rs_id_out); else passed++;
    total++; if (b_output_valid !== 1'b0 || b_result !== 64'h0) $display("[TB] FAIL reset_wide: got valid %b result %h expected 0/0", b_output_valid, b_result); else passed++;
    rst = 1'b0;
  endtask

  // Unsigned quotient with tag/address passthrough and full latency.
  task automatic test_basic();
    int lat;
    issue32(32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd17, 1'b1, lat);
    total++; if (a_result !== 32'd3) $display("[TB] FAIL basic_result: got %h expected %h", a_result, 32'd3); else passed++;
    total++; if (a_ov !== 1'b0) $display("[TB] FAIL basic_ov: got %b expected 0", a_ov); else passed++;
    total++; if (lat != 34) $display("[TB] FAIL basic_latency: got %0d expected 34", lat); else passed++;
    total++; if (a_rs_id_out !== 5'd9 || a_addr_out !== 5'd17) $display("[TB] FAIL basic_tag: got %0d/%0d expected 9/17", a_rs_id_out, a_addr_out); else passed++;
    total++; if (a_ov_valid !== 1'b0) $display("[TB] FAIL basic_ov_valid: got %b expected 0", a_ov_valid); else passed++;
  endtask

  // Signed quotient and remainder sign handling.
  task automatic test_signed();
    int lat;
    issue32(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, lat);
    total++; if (a_result !== 32'hFFFFFFFD) $display("[TB] FAIL signed_quo: got %h expected FFFFFFFD", a_result); else passed++;
    total++; if (a_cr0_valid !== 1'b1) $display("[TB] FAIL signed_cr0_valid: got %b expected 1", a_cr0_valid); else passed++;
    issue32(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1, lat);
    total++; if (a_result !== 32'hFFFFFFFF) $display("[TB] FAIL signed_rem_neg: got %h expected FFFFFFFF", a_result); else passed++;
    issue32(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1, lat);
    total++; if (a_result !== 32'd1) $display("[TB] FAIL signed_rem_pos: got %h expected 1", a_result); else passed++;
  endtask

  // Divide by zero, signed MIN/-1, and the same bit pattern treated unsigned.
  task automatic test_exceptions();
    int lat;
    issue32(32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, lat);
    total++; if (a_result !== 32'h0 || a_ov !== 1'b1) $display("[TB] FAIL divzero: got result %h ov %b expected 0/1", a_result, a_ov); else passed++;
    total++; if (a_ov_valid !== 1'b1) $display("[TB] FAIL divzero_ov_valid: got %b expected 1", a_ov_valid); else passed++;
    total++; if (lat != 2) $display("[TB] FAIL divzero_latency: got %0d expected 2", lat); else passed++;
    issue32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, lat);
    total++; if (a_result !== 32'h0 || a_ov !== 1'b1) $display("[TB] FAIL minneg1: got result %h ov %b expected 0/1", a_result, a_ov); else passed++;
    total++; if (lat != 2) $display("[TB] FAIL minneg1_latency: got %0d expected 2", lat); else passed++;
    issue32(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, lat);
    total++; if (a_result !== 32'h0 || a_ov !== 1'b0) $display("[TB] FAIL unsigned_big_quo: got result %h ov %b expected 0/0", a_result, a_ov); else passed++;
    total++; if (lat != 34) $display("[TB] FAIL unsigned_big_latency: got %0d expected 34", lat); else passed++;
    issue32(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 1'b1, lat);
    total++; if (a_result !== 32'h80000000) $display("[TB] FAIL unsigned_big_rem: got %h expected 80000000", a_result); else passed++;
  endtask

  // Hold the result under backpressure, then release it while a new op is
  // offered in the same cycle.
  task automatic test_back_to_back();
    int lat;
    bit found;
    issue32(32'd100, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 5'd13, 1'b0, lat);
    total++; if (a_result !== 32'd11) $display("[TB] FAIL bp_result: got %h expected %h", a_result, 32'd11); else passed++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (a_output_valid !== 1'b1 || a_result !== 32'd11 || a_input_ready !== 1'b0 || a_rs_id_out !== 5'd12)
        $display("[TB] FAIL bp_hold cycle %0d: got valid %b result %h ready %b tag %0d expected 1/0000000b/0/12",
                 c, a_output_valid, a_result, a_input_ready, a_rs_id_out);
      else passed++;
    end
    a_op1 = 32'd20; a_op2 = 32'd4; a_signed = 1'b0; a_rem = 1'b0;
    a_rs_id_in = 5'd21; a_input_valid = 1'b1; a_output_ready = 1'b1;
    #1;
    total++; if (a_input_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b expected 1", a_input_ready); else passed++;
    @(posedge clk);
    #1 a_input_valid = 1'b0;
    @(negedge clk);
    total++; if (a_output_valid !== 1'b0) $display("[TB] FAIL b2b_valid_drop: got %b expected 0", a_output_valid); else passed++;
    lat = 1;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (a_output_valid) begin found = 1'b1; break; end
      lat++;
      @(negedge clk);
    end
    if (!found) lat = -1;
    total++; if (a_result !== 32'd5 || a_rs_id_out !== 5'd21) $display("[TB] FAIL b2b_result: got %h tag %0d expected 5/21", a_result, a_rs_id_out); else passed++;
    total++; if (lat != 34) $display("[TB] FAIL b2b_latency: got %0d expected 34", lat); else passed++;
  endtask

  // 64-bit operands with four quotient bits per cycle.
  task automatic test_wide();
    int lat;
    issue64(64'hFFFFFFFFFFFFFFFF, 64'd3, 1'b0, 1'b0, lat);
    total++; if (b_result !== 64'h5555555555555555) $display("[TB] FAIL wide_quo: got %h expected 5555555555555555", b_result); else passed++;
    total++; if (lat != 18) $display("[TB] FAIL wide_latency: got %0d expected 18", lat); else passed++;
    issue64(64'd100, 64'd7, 1'b0, 1'b1, lat);
    total++; if (b_result !== 64'd2) $display("[TB] FAIL wide_rem: got %h expected 2", b_result); else passed++;
    issue64(64'hFFFFFFFFFFFFFF9C, 64'd7, 1'b1, 1'b0, lat);
    total++; if (b_result !== 64'hFFFFFFFFFFFFFFF2) $display("[TB] FAIL wide_signed_quo: got %h expected FFFFFFFFFFFFFFF2", b_result); else passed++;
    issue64(64'hFFFFFFFFFFFFFF9C, 64'd7, 1'b1, 1'b1, lat);
    total++; if (b_result !== 64'hFFFFFFFFFFFFFFFE) $display("[TB] FAIL wide_signed_rem: got %h expected FFFFFFFFFFFFFFFE", b_result); else passed++;
  endtask

  // Reset during iteration drops the op; the unit then works normally.
  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(negedge clk);
    a_op1 = 32'd100; a_op2 = 32'd3; a_signed = 1'b0; a_rem = 1'b0;
    a_output_ready = 1'b1; a_input_valid = 1'b1;
    @(posedge clk);
    #1 a_input_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (a_output_valid !== 1'b0 || a_input_ready !== 1'b1) $display("[TB] FAIL rstmid_state: got valid %b ready %b expected 0/1", a_output_valid, a_input_ready); else passed++;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_output_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("[TB] FAIL rstmid_discard: got output_valid seen %b expected 0", seen); else passed++;
    issue32(32'd9, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd8, 1'b1, lat);
    total++; if (a_result !== 32'd3) $display("[TB] FAIL rstmid_next: got %h expected 3", a_result); else passed++;
    total++; if (lat != 34) $display("[TB] FAIL rstmid_latency: got %0d expected 34", lat); else passed++;
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_exceptions();
    test_back_to_back();
    test_wide();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
